// File: rtl/inst_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : inst_loader_pkg                                        |
// | Description : Shared types and frame constants for the boot loader  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package inst_loader_pkg;

  localparam int c_LEN_W          = 16;  // frame length field width
  localparam int c_BYTES_PER_WORD = 4;   // payload bytes per memory word
  localparam int c_WORD_STRIDE    = 4;   // byte address step per word
  localparam int c_IDX_W          = 2;   // byte index width inside a word

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_CHK   = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } state_e;

endpackage
`default_nettype wire

// File: rtl/inst_loader_asm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : inst_loader_asm                                        |
// | Description : Byte-to-word assembler (little-endian) with XOR check  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module inst_loader_asm
  import inst_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,       // asynchronous, active-low
  input  logic        clear,       // restart assembly for a new frame
  input  logic        byte_en,     // payload byte accepted this cycle
  input  logic [7:0]  byte_in,
  output logic [31:0] word,        // assembled word, complete after the 4th byte
  output logic [7:0]  xor_acc,     // running XOR of all payload bytes
  output logic        word_ready   // 4th byte of a word is being accepted
);

  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_BYTES_PER_WORD - 1);

  logic [31:0]        shreg_q, shreg_d;
  logic [c_IDX_W-1:0] idx_q,   idx_d;
  logic [7:0]         acc_q,   acc_d;

  // Next-state: bytes shift in from the top so the first byte ends up as the LSB
  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    if (clear) begin
      shreg_d = 32'd0;
      idx_d   = '0;
      acc_d   = 8'd0;
    end else if (byte_en) begin
      shreg_d = {byte_in, shreg_q[31:8]};
      idx_d   = idx_q + c_IDX_W'(1);
      acc_d   = acc_q ^ byte_in;
    end
  end

  // Assembler registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q <= 32'd0;
      idx_q   <= '0;
      acc_q   <= 8'd0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

  assign word       = shreg_q;
  assign xor_acc    = acc_q;
  assign word_ready = byte_en && (idx_q == c_LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/inst_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : inst_loader                                            |
// | Description : Framed byte-stream boot loader for instruction memory  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,       // asynchronous, active-low
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_wr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  localparam logic [c_LEN_W-1:0] c_MAX_LEN = c_LEN_W'(MAX_WORDS);

  state_e             state_q, state_d;
  logic [c_LEN_W-1:0] len_q, len_d;
  logic [c_LEN_W-1:0] word_count_q, word_count_d;
  logic               rx_ready_q, rx_ready_d;
  logic               mem_wr_q, mem_wr_d;
  logic               cpu_hold_q, cpu_hold_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic               w_accept;
  logic               w_start_ok;
  logic               w_data_byte;
  logic [c_LEN_W-1:0] w_len_full;
  logic               w_len_bad;
  logic [c_LEN_W-1:0] w_wc_next;
  logic [31:0]        w_asm_word;
  logic [7:0]         w_xor_acc;
  logic               w_word_ready;

  assign w_accept    = rx_valid && rx_ready_q;
  assign w_start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                 (state_q == ST_ERR));
  assign w_data_byte = w_accept && (state_q == ST_DATA);
  assign w_len_full  = {rx_data, len_q[7:0]};
  assign w_len_bad   = (w_len_full == '0) || (w_len_full > c_MAX_LEN);
  assign w_wc_next   = word_count_q + c_LEN_W'(1);

  inst_loader_asm u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (w_start_ok),
    .byte_en    (w_data_byte),
    .byte_in    (rx_data),
    .word       (w_asm_word),
    .xor_acc    (w_xor_acc),
    .word_ready (w_word_ready)
  );

  // FSM next state, length capture and word counter; registered outputs decode the next state
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_count_d = word_count_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d      = ST_LEN0;
          word_count_d = '0;
        end
      end
      ST_LEN0: begin
        if (w_accept) begin
          len_d[7:0] = rx_data;
          state_d    = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (w_accept) begin
          len_d[15:8] = rx_data;
          state_d     = w_len_bad ? ST_ERR : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_word_ready) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        word_count_d = w_wc_next;
        state_d      = (w_wc_next == len_q) ? ST_CHK : ST_DATA;
      end
      ST_CHK: begin
        if (w_accept) state_d = (rx_data == w_xor_acc) ? ST_DONE : ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase

    rx_ready_d = (state_d == ST_LEN0) || (state_d == ST_LEN1) ||
                 (state_d == ST_DATA) || (state_d == ST_CHK);
    mem_wr_d   = (state_d == ST_WRITE);
    cpu_hold_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d     = (state_d == ST_DONE);
    error_d    = (state_d == ST_ERR);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      word_count_q <= '0;
      rx_ready_q   <= 1'b0;
      mem_wr_q     <= 1'b0;
      cpu_hold_q   <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_count_q <= word_count_d;
      rx_ready_q   <= rx_ready_d;
      mem_wr_q     <= mem_wr_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  // word_count still holds the pre-increment value during WRITE, so it addresses the current word
  assign mem_waddr  = BASE_ADDR + (32'(word_count_q) * 32'(c_WORD_STRIDE));
  assign mem_wdata  = w_asm_word;
  assign mem_wr     = mem_wr_q;
  assign rx_ready   = rx_ready_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = word_count_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_inst_loader                                         |
// | Description : Self-checking bench for the framed boot loader         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;

  logic        rdy0, wr0, hold0, done0, err0;
  logic [31:0] waddr0, wdata0;
  logic [15:0] wc0;
  logic        rdy1, wr1, hold1, done1, err1;
  logic [31:0] waddr1, wdata1;
  logic [15:0] wc1;

  int checks = 0;
  int errors = 0;
  int viol   = 0;
  logic [31:0] wa0[$], wd0[$], wa1[$], wd1[$];

  typedef struct {
    int n;          // programmed length field
    bit corrupt;    // flip bit 0 of the checksum byte
    int maxgap;     // max idle cycles before each payload/chk byte
    bit inject;     // pulse start in the middle of DATA
    bit exp_done;
    bit exp_err;
    bit exp_hold;
    int exp_wc;
    int exp_writes;
  } row_t;

  row_t tbl[7];

  inst_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256)) dut0 (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rdy0), .mem_wr(wr0), .mem_waddr(waddr0), .mem_wdata(wdata0),
    .cpu_hold(hold0), .done(done0), .error(err0), .word_count(wc0)
  );

  inst_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(256)) dut1 (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rdy1), .mem_wr(wr1), .mem_waddr(waddr1), .mem_wdata(wdata1),
    .cpu_hold(hold1), .done(done1), .error(err1), .word_count(wc1)
  );

  always #5 clk = ~clk;

  // Record memory writes of both instances; a write cycle must never offer rx_ready
  always @(negedge clk) begin
    if (wr0) begin
      wa0.push_back(waddr0);
      wd0.push_back(wdata0);
      if (rdy0) viol++;
    end
    if (wr1) begin
      wa1.push_back(waddr1);
      wd1.push_back(wdata1);
      if (rdy1) viol++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wgen(input int i);
    if (i == 0) return 32'h0050_0093;
    if (i == 1) return 32'h0010_0113;
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // All stimulus tasks start and end at posedge+1
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    int t;
    rx_valid = 1'b0;
    repeat (gap) step();
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    got = 1'b0;
    while (!got) begin
      @(negedge clk);
      got = rdy0;
      step();
      t++;
      if (!got && t > 1000) begin
        errors++;
        $display("FAIL byte_timeout: got no rx_ready expected rx_ready within 1000 cycles");
        break;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rx_ready"},   32'(rdy0),   32'd0);
    chk({tag, "_mem_wr"},     32'(wr0),    32'd0);
    chk({tag, "_mem_waddr"},  waddr0,      32'h0);
    chk({tag, "_mem_wdata"},  wdata0,      32'h0);
    chk({tag, "_cpu_hold"},   32'(hold0),  32'd0);
    chk({tag, "_done"},       32'(done0),  32'd0);
    chk({tag, "_error"},      32'(err0),   32'd0);
    chk({tag, "_word_count"}, 32'(wc0),    32'd0);
    chk({tag, "_waddr_b100"}, waddr1,      32'h100);
  endtask

  task automatic run_row(input int idx, input row_t r);
    logic [15:0] len;
    logic [7:0]  acc;
    logic [31:0] w;
    int          gap;
    int          busy;
    string       tag;
    tag = $sformatf("row%0d", idx);
    wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
    viol = 0;
    pulse_start();
    @(negedge clk);
    chk({tag, "_start_hold"},  32'(hold0), 32'd1);
    chk({tag, "_start_done"},  32'(done0), 32'd0);
    chk({tag, "_start_error"}, 32'(err0),  32'd0);
    chk({tag, "_start_wc"},    32'(wc0),   32'd0);
    step();
    len = 16'(r.n);
    send_byte(len[7:0], 0);
    send_byte(len[15:8], 0);
    if (r.exp_writes == 0) begin
      // Bad length: a payload byte is offered but must never be taken
      rx_valid = 1'b1;
      rx_data  = 8'h55;
      busy = 0;
      repeat (4) begin
        @(negedge clk);
        if (rdy0) busy++;
        step();
      end
      rx_valid = 1'b0;
      chk({tag, "_no_payload_ready"}, 32'(busy), 32'd0);
      @(negedge clk);
    end else begin
      acc = 8'h00;
      for (int i = 0; i < r.n; i++) begin
        w = wgen(i);
        for (int b = 0; b < 4; b++) begin
          acc ^= w[8*b +: 8];
          gap = (r.maxgap > 0) ? int'($urandom_range(0, r.maxgap)) : 0;
          send_byte(w[8*b +: 8], gap);
          if (r.inject && i == 0 && b == 1) pulse_start();
        end
      end
      gap = (r.maxgap > 0) ? int'($urandom_range(0, r.maxgap)) : 0;
      send_byte(acc ^ {7'd0, r.corrupt}, gap);
      // Outcome must be visible in the cycle right after the CHK byte
      @(negedge clk);
    end
    chk({tag, "_done"},       32'(done0), 32'(r.exp_done));
    chk({tag, "_error"},      32'(err0),  32'(r.exp_err));
    chk({tag, "_cpu_hold"},   32'(hold0), 32'(r.exp_hold));
    chk({tag, "_word_count"}, 32'(wc0),   32'(r.exp_wc));
    chk({tag, "_b100_done"},  32'(done1), 32'(r.exp_done));
    chk({tag, "_writes"},     32'(wa0.size()), 32'(r.exp_writes));
    chk({tag, "_writes_b100"}, 32'(wa1.size()), 32'(r.exp_writes));
    chk({tag, "_ready_in_write"}, 32'(viol), 32'd0);
    for (int i = 0; i < r.exp_writes && i < wa0.size() && i < wa1.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i),      wa0[i], 32'(i) * 32'd4);
      chk($sformatf("%s_data%0d", tag, i),      wd0[i], wgen(i));
      chk($sformatf("%s_addr%0d_b100", tag, i), wa1[i], 32'h100 + 32'(i) * 32'd4);
      chk($sformatf("%s_data%0d_b100", tag, i), wd1[i], wgen(i));
    end
    step();
  endtask

  initial begin
    //           n    corr gap inj done err hold wc   writes
    tbl[0] = '{  2,   0,   0,  0,  1,   0,  0,   2,   2 };
    tbl[1] = '{  2,   1,   0,  0,  0,   1,  1,   2,   2 };
    tbl[2] = '{  0,   0,   0,  0,  0,   1,  1,   0,   0 };
    tbl[3] = '{  257, 0,   0,  0,  0,   1,  1,   0,   0 };
    tbl[4] = '{  1,   0,   0,  0,  1,   0,  0,   1,   1 };
    tbl[5] = '{  2,   0,   7,  1,  1,   0,  0,   2,   2 };
    tbl[6] = '{  256, 0,   0,  0,  1,   0,  0,   256, 256 };

    reset    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
    check_reset_values("por");
    step();
    reset = 1'b1;
    step();

    for (int i = 0; i < 7; i++) run_row(i, tbl[i]);

    // Reset asserted mid-load, after the 6th payload byte
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int k = 0; k < 6; k++) begin
      logic [31:0] w;
      w = wgen(k / 4);
      send_byte(w[8*(k%4) +: 8], 0);
    end
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("midreset");
    step();
    reset = 1'b1;
    step();
    run_row(7, tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/inst_loader.md
# inst_loader

Boot-time program loader that writes the 32-bit instruction memory. It receives a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit words and issues single-cycle writes on the memory write port. While loading, it holds the processor core in reset; the core then fetches the loaded program from address BASE_ADDR. It is the writer side of the instruction-fetch read path.

## Interface
- BASE_ADDR, 32'h0000_0000, byte address of the first word written
- MAX_WORDS, 256, largest accepted program length in words (≤ 65535)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE and ERR
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data is valid
- rx_ready  out  1  loader accepts a byte this cycle
- mem_wr  out  1  instruction-memory write strobe, one cycle per word
- mem_waddr  out  32  byte write address
- mem_wdata  out  32  write word
- cpu_hold  out  1  holds the core in reset while high
- done  out  1  load completed successfully (sticky)
- error  out  1  load failed (sticky)
- word_count  out  16  words written so far in the current load

## Operation
- Frame format: LEN_LO, LEN_HI (N words, little-endian), then 4N payload bytes (each word LSB first), then CHK = XOR of all 4N payload bytes.
- A byte transfers on a cycle where rx_valid && rx_ready.
- FSM states: IDLE, LEN0, LEN1, DATA, WRITE, CHK, DONE, ERR.
- IDLE: on start, go to LEN0 and raise cpu_hold. Clear word_count, the byte index and the XOR accumulator.
- LEN0: accept a byte into len[7:0], then go to LEN1.
- LEN1: accept a byte into len[15:8]. If N == 0 or N > MAX_WORDS, go to ERR. Otherwise go to DATA.
- DATA: accept bytes into the shift register at byte index 0..3 and fold each byte into the XOR accumulator. After the 4th byte, go to WRITE.
- WRITE: for one cycle, drive mem_wr = 1, mem_waddr = BASE_ADDR + 4·word_count and mem_wdata = the assembled word. Then increment word_count. Go to CHK if word_count+1 == N, else go to DATA.
- CHK: accept one byte. If it equals the accumulator, go to DONE; otherwise go to ERR.
- DONE: drive done = 1 and cpu_hold = 0. On start, re-enter LEN0 and clear done.
- ERR: drive error = 1 and keep cpu_hold = 1 so the core never runs a partial image. On start, re-enter LEN0 and clear error.
- Width rules:
  - The address adder is 32-bit and wraps modulo 2^32 with no flag.
  - word_count is 16-bit. It cannot overflow because N ≤ MAX_WORDS.
- A start pulse in LEN0, LEN1, DATA, WRITE or CHK is ignored.
- A byte offered in IDLE, WRITE, DONE or ERR is not accepted (rx_ready = 0).

## Timing
- Reset values: state = IDLE, rx_ready = 0, mem_wr = 0, mem_waddr = BASE_ADDR, mem_wdata = 0, cpu_hold = 0, done = 0, error = 0, word_count = 0.
- Reset asserted mid-load returns to IDLE immediately and releases cpu_hold. The partially written memory is not cleaned up.
- rx_ready is a registered state decode: 1 in LEN0, LEN1, DATA and CHK, 0 elsewhere. It does not depend combinationally on rx_valid.
- rx_ready drops on the cycle after the 4th byte of each word (WRITE). It rises again on the following cycle. Peak rate is 4 bytes per 5 cycles.
- mem_wr is registered and high for exactly one cycle per word. mem_waddr and mem_wdata are stable during that cycle.
- cpu_hold rises the cycle after start is sampled.
- cpu_hold falls, and done rises, the cycle after the CHK byte is accepted.
- Latency from the final CHK byte to the done/error assertion is 1 cycle.
- rx_valid may stall for any number of cycles in any accepting state. The loader waits with no timeout.

## Structure
- A shared package holds the state enum type and the frame constants: length width 16, bytes per word 4, word stride 4.
- One sub-module: inst_loader_asm, the byte-to-word assembler. It contains the 32-bit shift register, the 2-bit byte index, the XOR accumulator and a word_ready flag.
- The FSM, address generator and counters stay in the top module.

## Test plan
- Load N=2, words 32'h00500093 and 32'h00100113, CHK = XOR of the 8 payload bytes.
  - mem_wr pulses twice: at address 0x0 with 00500093, then at 0x4 with 00100113.
  - done=1, cpu_hold=0, word_count=2.
- Same frame with CHK corrupted by XOR 0x01: both memory writes still occur; error=1, done=0, cpu_hold stays 1.
- LEN = 0x0000: loader goes to ERR after LEN_HI and accepts no payload byte. Also LEN = MAX_WORDS+1: ERR immediately, error=1.
- Random rx_valid gaps of 0–7 cycles with a start pulse injected during DATA: start is ignored, the image written is identical to the gap-free run, and rx_ready=0 in every WRITE cycle.
- Assert reset after the 6th payload byte: all outputs return to their reset values asynchronously. A subsequent start plus a full frame completes with done=1.
- From DONE, pulse start and send a second frame with BASE_ADDR=32'h100: done clears, cpu_hold rises again, writes land at 0x100 upward, and done reasserts.
